// File: rtl/core_pkg.sv
// Shared types and constants for the multi-cycle control sequencer.
package core_pkg;

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned WAIT_W = 4;

  localparam logic [8:0] HALT_CODE_DEF = 9'h1FF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_MEM   = 3'd3,
    ST_WB    = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/core_sequencer_if.sv
// Harness/ROM/decoder-facing bundle of the sequencer: run handshake, PC/IR and strobes.
interface core_sequencer_if #(
  parameter int unsigned D = 12,
  parameter int unsigned W = 9
);
  import core_pkg::*;

  logic             req;
  logic             done;
  logic             timeout;
  logic [D-1:0]     prog_ctr;
  logic [W-1:0]     instr_in;
  logic [W-1:0]     ir;
  logic             reg_we_req;
  logic             mem_we_req;
  logic             mem_rd_req;
  logic             abs_jump;
  logic             rel_jump;
  logic [D-1:0]     target;
  logic             reg_wr_en;
  logic             mem_wr_en;
  logic [2:0]       state;
  logic [CNT_W-1:0] instr_cnt;

  modport master (
    output req, instr_in, reg_we_req, mem_we_req, mem_rd_req,
           abs_jump, rel_jump, target,
    input  done, timeout, prog_ctr, ir, reg_wr_en, mem_wr_en, state, instr_cnt
  );

  modport slave (
    input  req, instr_in, reg_we_req, mem_we_req, mem_rd_req,
           abs_jump, rel_jump, target,
    output done, timeout, prog_ctr, ir, reg_wr_en, mem_wr_en, state, instr_cnt
  );

endinterface

// File: rtl/core_sequencer_pc_next.sv
// Combinational next-PC select: absolute jump beats relative jump beats sequential step.
module pc_next #(
  parameter int unsigned D = 12
) (
  input  logic [D-1:0] prog_ctr_i,
  input  logic [D-1:0] target_i,
  input  logic         abs_jump_i,
  input  logic         rel_jump_i,
  output logic [D-1:0] next_pc_c_o
);

  // Relative target is a signed D-bit offset; plain D-bit addition wraps modulo 2^D.
  always_comb begin
    next_pc_c_o = prog_ctr_i + D'(1);
    if (abs_jump_i) begin
      next_pc_c_o = target_i;
    end else if (rel_jump_i) begin
      next_pc_c_o = prog_ctr_i + target_i;
    end
  end

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle FETCH/EXEC/MEM/WB sequencer with four-phase run handshake,
// configurable memory wait states and an instruction-count watchdog.
module core_sequencer
  import core_pkg::*;
#(
  parameter int unsigned    D         = 12,
  parameter int unsigned    W         = 9,
  parameter logic [D-1:0]   START_PC  = '0,
  parameter logic [W-1:0]   HALT_CODE = W'(HALT_CODE_DEF),
  parameter int unsigned    MEM_LAT   = 1,
  parameter int unsigned    MAX_CYC   = 4095
) (
  input  logic            clk,
  input  logic            reset,
  core_sequencer_if.slave bus
);

  state_t            state_q;
  logic [D-1:0]      pc_q;
  logic [D-1:0]      pc_d;
  logic [W-1:0]      ir_q;
  logic              done_q;
  logic              timeout_q;
  logic              reg_wr_en_q;
  logic              mem_wr_en_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_inc_c;
  logic [WAIT_W-1:0] wait_q;
  logic              is_mem_c;

  pc_next #(.D(D)) u_pc_next (
    .prog_ctr_i  (pc_q),
    .target_i    (bus.target),
    .abs_jump_i  (bus.abs_jump),
    .rel_jump_i  (bus.rel_jump),
    .next_pc_c_o (pc_d)
  );

  assign cnt_inc_c = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
  assign is_mem_c  = bus.mem_we_req | bus.mem_rd_req;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      pc_q        <= START_PC;
      ir_q        <= '0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      reg_wr_en_q <= 1'b0;
      mem_wr_en_q <= 1'b0;
      cnt_q       <= '0;
      wait_q      <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (bus.req) begin
            state_q   <= ST_FETCH;
            pc_q      <= START_PC;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
          end
        end
        ST_FETCH: begin
          ir_q    <= bus.instr_in;
          state_q <= ST_EXEC;
        end
        ST_EXEC: begin
          if (ir_q == HALT_CODE) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else if (is_mem_c) begin
            state_q     <= ST_MEM;
            wait_q      <= WAIT_W'(MEM_LAT);
            mem_wr_en_q <= bus.mem_we_req;
          end else begin
            state_q     <= ST_WB;
            reg_wr_en_q <= bus.reg_we_req;
          end
        end
        // Write strobe is a single pulse on the first MEM cycle.
        ST_MEM: begin
          mem_wr_en_q <= 1'b0;
          if (wait_q == '0) begin
            state_q     <= ST_WB;
            reg_wr_en_q <= bus.reg_we_req;
          end else begin
            wait_q <= wait_q - WAIT_W'(1);
          end
        end
        ST_WB: begin
          reg_wr_en_q <= 1'b0;
          pc_q        <= pc_d;
          cnt_q       <= cnt_inc_c;
          if (cnt_inc_c == CNT_W'(MAX_CYC)) begin
            state_q   <= ST_DONE;
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
          end else begin
            state_q <= ST_FETCH;
          end
        end
        ST_DONE: begin
          if (!bus.req) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.done      = done_q;
  assign bus.timeout   = timeout_q;
  assign bus.prog_ctr  = pc_q;
  assign bus.ir        = ir_q;
  assign bus.reg_wr_en = reg_wr_en_q;
  assign bus.mem_wr_en = mem_wr_en_q;
  assign bus.state     = state_q;
  assign bus.instr_cnt = cnt_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Bench for core_sequencer: directed and random programs against a program-level reference model.
module tb_core_sequencer;
  import core_pkg::*;

  localparam logic [8:0] HALT = 9'h1FF;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  core_sequencer_if #(.D(12), .W(9)) b0 ();
  core_sequencer_if #(.D(12), .W(9)) b1 ();

  core_sequencer #(.MEM_LAT(1), .MAX_CYC(4095)) dut0 (.clk(clk), .reset(rst_n), .bus(b0.slave));
  core_sequencer #(.MEM_LAT(3), .MAX_CYC(4))    dut1 (.clk(clk), .reset(rst_n), .bus(b1.slave));

  // Instruction encoding: [8:7] class (0 ALU, 1 store, 2 load, 3 branch), [6] abs, [5] rel, [4:0] target.
  function automatic logic [16:0] dec(input logic [8:0] i);
    logic [11:0] t;
    t = i[6] ? {7'b0, i[4:0]} : {{7{i[4]}}, i[4:0]};
    case (i[8:7])
      2'd0:    dec = {5'b10000, t};
      2'd1:    dec = {5'b01000, t};
      2'd2:    dec = {5'b10100, t};
      default: dec = {3'b000, i[6], i[5], t};
    endcase
  endfunction

  logic [8:0] rom0 [4096];
  logic [8:0] rom1 [4096];
  logic       req_v [2];

  assign b0.req      = req_v[0];
  assign b1.req      = req_v[1];
  assign b0.instr_in = rom0[b0.prog_ctr];
  assign b1.instr_in = rom1[b1.prog_ctr];
  assign {b0.reg_we_req, b0.mem_we_req, b0.mem_rd_req, b0.abs_jump, b0.rel_jump, b0.target} = dec(b0.ir);
  assign {b1.reg_we_req, b1.mem_we_req, b1.mem_rd_req, b1.abs_jump, b1.rel_jump, b1.target} = dec(b1.ir);

  logic [2:0]  st_w  [2];
  logic        done_w[2], to_w[2], rwe_w[2], mwe_w[2];
  logic [11:0] pc_w  [2];
  logic [8:0]  ir_w  [2];
  logic [15:0] cnt_w [2];
  assign st_w[0] = b0.state;     assign st_w[1] = b1.state;
  assign done_w[0] = b0.done;    assign done_w[1] = b1.done;
  assign to_w[0] = b0.timeout;   assign to_w[1] = b1.timeout;
  assign rwe_w[0] = b0.reg_wr_en; assign rwe_w[1] = b1.reg_wr_en;
  assign mwe_w[0] = b0.mem_wr_en; assign mwe_w[1] = b1.mem_wr_en;
  assign pc_w[0] = b0.prog_ctr;  assign pc_w[1] = b1.prog_ctr;
  assign ir_w[0] = b0.ir;        assign ir_w[1] = b1.ir;
  assign cnt_w[0] = b0.instr_cnt; assign cnt_w[1] = b1.instr_cnt;

  int lat_p[2] = '{1, 3};
  int max_p[2] = '{4095, 4};

  int n_vec = 0;
  int n_err = 0;

  int m_cycles, m_regw, m_memw, m_memops, m_cnt, m_to, m_pc;
  int m_trace[$];
  int r_cyc, r_regw, r_memw, r_memc, r_bad, r_firstwb, r_cnt, r_to, r_pc, r_done;
  int r_trace[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_rom(input int w, input int a, input logic [8:0] v);
    if (w == 0) rom0[a] = v; else rom1[a] = v;
  endtask

  function automatic logic [8:0] get_rom(input int w, input int a);
    return (w == 0) ? rom0[a] : rom1[a];
  endfunction

  task automatic clear_rom(input int w);
    for (int a = 0; a < 4096; a++) set_rom(w, a, HALT);
  endtask

  // Program-level model: walks the ROM, accumulating cost, strobes and the fetch trace.
  function automatic void model(input int w);
    int pc, off;
    logic [8:0] ins;
    m_cycles = 0; m_regw = 0; m_memw = 0; m_memops = 0; m_cnt = 0; m_to = 0;
    m_trace.delete();
    pc = 0;
    for (int k = 0; k < 100000; k++) begin
      ins = get_rom(w, pc);
      m_trace.push_back(pc);
      if (ins == HALT) begin
        m_cycles += 2;
        break;
      end
      if (ins[8:7] == 2'd1 || ins[8:7] == 2'd2) begin
        m_cycles += 4 + lat_p[w];
        m_memops++;
      end else begin
        m_cycles += 3;
      end
      if (ins[8:7] == 2'd0 || ins[8:7] == 2'd2) m_regw++;
      if (ins[8:7] == 2'd1) m_memw++;
      if (ins[8:7] == 2'd3 && ins[6]) pc = int'(ins[4:0]);
      else if (ins[8:7] == 2'd3 && ins[5]) begin
        off = ins[4] ? int'(ins[4:0]) - 32 : int'(ins[4:0]);
        pc  = (pc + off + 4096) % 4096;
      end else pc = (pc + 1) % 4096;
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt == max_p[w]) begin
        m_to = 1;
        break;
      end
    end
    m_pc = pc;
  endfunction

  task automatic run(input int w, input string nm);
    logic [2:0] prev;
    model(w);
    r_cyc = 0; r_regw = 0; r_memw = 0; r_memc = 0; r_bad = 0; r_firstwb = 0; r_done = 0;
    r_trace.delete();
    prev = ST_IDLE;
    req_v[w] = 1'b1;
    while (r_done == 0 && r_cyc < 2000) begin
      @(posedge clk); #1;
      r_cyc++;
      if (st_w[w] == ST_FETCH) r_trace.push_back(int'(pc_w[w]));
      if (st_w[w] == ST_MEM) r_memc++;
      if (mwe_w[w]) begin
        r_memw++;
        if (!(st_w[w] == ST_MEM && prev != ST_MEM)) r_bad++;
      end
      if (rwe_w[w]) begin
        r_regw++;
        if (st_w[w] != ST_WB) r_bad++;
      end
      if (st_w[w] == ST_WB && r_firstwb == 0) r_firstwb = r_cyc;
      r_done = int'(done_w[w]);
      prev = st_w[w];
    end
    r_cnt = int'(cnt_w[w]); r_to = int'(to_w[w]); r_pc = int'(pc_w[w]);
    chk({nm, ".done_seen"}, r_done, 1);
    chk({nm, ".cycles"}, r_cyc - 1, m_cycles);
    chk({nm, ".reg_pulses"}, r_regw, m_regw);
    chk({nm, ".mem_pulses"}, r_memw, m_memw);
    chk({nm, ".mem_cycles"}, r_memc, m_memops * (lat_p[w] + 1));
    chk({nm, ".strobe_placement"}, r_bad, 0);
    chk({nm, ".instr_cnt"}, r_cnt, m_cnt);
    chk({nm, ".timeout"}, r_to, m_to);
    chk({nm, ".final_pc"}, r_pc, m_pc);
    chk({nm, ".trace_len"}, r_trace.size(), m_trace.size());
    for (int i = 0; i < r_trace.size() && i < m_trace.size(); i++)
      chk({nm, ".trace"}, r_trace[i], m_trace[i]);
    repeat (3) begin @(posedge clk); #1; end
    chk({nm, ".done_hold"}, done_w[w], 1'b1);
    chk({nm, ".pc_frozen"}, pc_w[w], 12'(m_pc));
    req_v[w] = 1'b0;
    @(posedge clk); #1;
    chk({nm, ".idle_after_drop"}, st_w[w], ST_IDLE);
    chk({nm, ".done_drop"}, done_w[w], 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    chk({nm, ".no_restart"}, st_w[w], ST_IDLE);
  endtask

  task automatic gen(input int w, input bit back);
    logic [8:0] ins;
    int r;
    clear_rom(w);
    for (int pc = 0; pc < 32; pc++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2: ins = {2'b00, 7'($urandom)};
        3:       ins = {2'b01, 7'($urandom)};
        4:       ins = {2'b10, 7'($urandom)};
        5:       ins = HALT;
        6, 7:    ins = back ? {4'b1101, 5'($urandom)} : {4'b1101, 5'($urandom_range(1, 15))};
        default: begin
          if (back) ins = {3'b111, 1'($urandom), 5'($urandom)};
          else if (pc < 31) ins = {3'b111, 1'($urandom), 5'($urandom_range(pc + 1, 31))};
          else ins = HALT;
        end
      endcase
      set_rom(w, pc, ins);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    req_v[0] = 1'b1;
    req_v[1] = 1'b0;
    clear_rom(0);
    clear_rom(1);
    for (int a = 0; a < 3; a++) set_rom(0, a, {2'b00, 7'($urandom)});

    // Reset dominates a held request.
    #2;
    for (int w = 0; w < 2; w++) begin
      chk("rst.state", st_w[w], ST_IDLE);
      chk("rst.pc", pc_w[w], 12'h000);
      chk("rst.ir", ir_w[w], 9'h000);
      chk("rst.done", done_w[w], 1'b0);
      chk("rst.timeout", to_w[w], 1'b0);
      chk("rst.reg_wr_en", rwe_w[w], 1'b0);
      chk("rst.mem_wr_en", mwe_w[w], 1'b0);
      chk("rst.instr_cnt", cnt_w[w], 16'h0000);
    end
    @(posedge clk); #1;
    chk("rst.held_idle", st_w[0], ST_IDLE);
    @(negedge clk);
    rst_n = 1'b1;

    run(0, "straight");
    chk("straight.cycles_abs", r_cyc - 1, 11);
    chk("straight.reg_abs", r_regw, 3);
    chk("straight.cnt_abs", r_cnt, 3);
    chk("straight.to_abs", r_to, 0);

    clear_rom(1);
    set_rom(1, 0, {2'b01, 7'($urandom)});
    run(1, "memwait");
    chk("memwait.first_wb", r_firstwb, 7);
    chk("memwait.mem_pulse", r_memw, 1);
    chk("memwait.mem_cycles_abs", r_memc, 4);
    chk("memwait.no_reg", r_regw, 0);

    clear_rom(1);
    set_rom(1, 0, 9'b11_1_0_00000);
    run(1, "watchdog");
    chk("watchdog.to_abs", r_to, 1);
    chk("watchdog.cnt_abs", r_cnt, 4);
    chk("watchdog.cycles_abs", r_cyc - 1, 12);

    clear_rom(1);
    set_rom(1, 0, 9'h000);
    set_rom(1, 1, 9'b11_0_1_11110);
    set_rom(1, 12'hFFF, 9'h000);
    run(1, "relwrap");
    chk("relwrap.pc_fff", r_trace[2], 12'hFFF);
    chk("relwrap.pc_wrap", r_trace[3], 12'h000);

    clear_rom(0);
    set_rom(0, 0, 9'h000);
    set_rom(0, 1, 9'b11_1_1_00101);
    run(0, "bothjump");
    chk("bothjump.pc", r_pc, 5);

    for (int k = 0; k < 6; k++) begin
      gen(0, 1'b0);
      run(0, "rand0");
      gen(1, 1'b1);
      run(1, "rand1");
    end

    // Asynchronous reset during the write pulse.
    clear_rom(1);
    set_rom(1, 0, {2'b01, 7'($urandom)});
    req_v[1] = 1'b1;
    for (int k = 0; k < 20 && st_w[1] != ST_MEM; k++) begin
      @(posedge clk); #1;
    end
    chk("midmem.pulse", mwe_w[1], 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midmem.mem_wr_en", mwe_w[1], 1'b0);
    chk("midmem.state", st_w[1], ST_IDLE);
    chk("midmem.pc", pc_w[1], 12'h000);
    chk("midmem.done", done_w[1], 1'b0);
    req_v[1] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midmem.stay_idle", st_w[1], ST_IDLE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
Parametrised multi-cycle control sequencer, the next-generation replacement for the single-cycle req/done program runner. Owns the program counter, instruction register and run handshake. Steps each instruction through FETCH/EXEC/MEM/WB with configurable data-memory wait states. Gates the register-file and data-memory write strobes, and reports completion or watchdog timeout to the test harness.

Parameters:
D, 12, program counter width; all PC arithmetic is modulo 2^D.
W, 9, instruction width.
START_PC, 0, PC loaded on each run start.
HALT_CODE, 9'h1FF (W bits), instruction pattern that ends a run.
MEM_LAT, 1, extra wait cycles in MEM; range 0..15.
MAX_CYC, 4095, watchdog limit in executed instructions; range 1..2^16-1.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-low; 0 forces the reset state immediately.
req  in  1  run request, four-phase handshake with done.
done  out  1  run complete.
timeout  out  1  run ended by the watchdog; valid while done=1.
prog_ctr  out  D  current PC, to the instruction ROM.
instr_in  in  W  machine code from the ROM for prog_ctr, combinational.
ir  out  W  latched instruction, feeds the decoder.
reg_we_req  in  1  decoder RegWrite for ir.
mem_we_req  in  1  decoder MemWrite for ir.
mem_rd_req  in  1  decoder MemToReg (load) for ir.
abs_jump  in  1  take absolute branch (already flag-qualified).
rel_jump  in  1  take relative branch (already flag-qualified).
target  in  D  absolute target, or signed relative offset.
reg_wr_en  out  1  gated register-file write strobe.
mem_wr_en  out  1  gated data-memory write strobe.
state  out  3  current FSM state, for debug.
instr_cnt  out  16  instructions retired in the current run.

Behaviour:
- Reset values: state=IDLE, prog_ctr=START_PC, ir=0, done=0, timeout=0, reg_wr_en=0, mem_wr_en=0, instr_cnt=0, wait counter=0.
- IDLE: done=0. On req=1, go to FETCH. In the same edge load prog_ctr=START_PC and clear instr_cnt and timeout.
- FETCH (1 cycle): ir <= instr_in, then go to EXEC.
- EXEC (1 cycle):
  - If ir==HALT_CODE, go to DONE; PC unchanged, no strobes, halt is not counted.
  - Else if mem_we_req|mem_rd_req, go to MEM with wait counter loaded to MEM_LAT.
  - Else go to WB.
- MEM: mem_wr_en=mem_we_req in the first MEM cycle only (single pulse). Counter decrements each cycle; go to WB on the cycle it reads 0. MEM_LAT=0 means exactly 1 MEM cycle; MEM_LAT=N means N+1 cycles.
- WB (1 cycle):
  - reg_wr_en=reg_we_req.
  - Next PC: abs_jump gives target. Else rel_jump gives prog_ctr+target (signed D-bit, wraps mod 2^D). Else prog_ctr+1 (D-1 wraps to 0).
  - If both jumps are asserted, abs wins.
  - instr_cnt increments, saturating at 16'hFFFF.
  - If the incremented count equals MAX_CYC, go to DONE with timeout=1. Else go to FETCH.
- DONE: done=1, strobes 0, PC and ir frozen. Stay while req=1. When req=0, go to IDLE and done drops in the same edge.
- req deasserting during FETCH/EXEC/MEM/WB is ignored; the run completes.
- req held high across DONE to IDLE does not restart the run; req must be seen low first (four-phase).
- Strobes are registered and asserted only during their state, never in IDLE/DONE/FETCH/EXEC.
- Reset low in any state returns to the reset values asynchronously. An in-flight write strobe drops immediately.
- Cycle cost per instruction: 3 for ALU/branch; 4+MEM_LAT for memory ops. The halt instruction costs 2 cycles (FETCH, EXEC) before DONE.

Decomposition:
- core_pkg holds: the state_t enum (IDLE, FETCH, EXEC, MEM, WB, DONE; 3-bit encoding), the default HALT_CODE, and the instr_cnt width constant (16).
- One sub-module: pc_next, purely combinational. Inputs: prog_ctr, target, abs_jump, rel_jump. Output: the next PC.
- The FSM, wait counter and watchdog stay in core_sequencer.

Test Plan:
- Reset/start: hold reset=0 with req=1. Expect all outputs at their reset values and prog_ctr=0. Release reset; the next edge enters FETCH, and done=0 throughout.
- Straight-line run: ROM holds 3 ALU ops (reg_we_req=1) then HALT_CODE at PC 3. Expect done=1 after 3*3+2=11 cycles from FETCH, 3 single-cycle reg_wr_en pulses, instr_cnt=3, timeout=0.
- Memory wait: MEM_LAT=3, one store at PC 0. Expect one mem_wr_en pulse on the first MEM cycle, 4 MEM cycles, WB at cycle 7, and no reg_wr_en.
- Branches: rel_jump with target=12'hFFE at PC 1 gives PC 12'hFFF. The next sequential step wraps to 0. abs_jump and rel_jump together with target=5 give PC 5.
- Watchdog: MAX_CYC=4, ROM is an infinite loop (abs_jump to 0). Expect done=1 and timeout=1 after the 4th WB, instr_cnt=4.
- Handshake/reset: hold req=1 in DONE and expect done stays 1. Drop req: IDLE and done=0 on the next edge, and no restart until req rises again. Pulse reset=0 mid-MEM and expect mem_wr_en=0 and state=IDLE immediately.
